line_buffer_scheduler: RTL and testbench

LINE_BUFFER_SCHEDULER -- requirements
Module: line_buffer_scheduler

---
 rtl/line_buffer_scheduler.sv | 128 ++++++++++++
 tb/tb_line_buffer_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_scheduler.sv
// rtl/line_buffer_scheduler.sv - write/read scheduler for three rotating line buffers feeding a 3x3 window engine
module line_buffer_scheduler #(
   parameter int ROW_LEN  = 96,
   parameter int IMG_ROWS = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [2:0] wr_en,
   output logic [6:0] wr_addr,
   input  logic       conv_stall,
   output logic       rd_en,
   output logic [6:0] rd_addr,
   output logic [1:0] k,
   output logic       row_done,
   output logic       frame_done,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_COMPUTE,
      S_ROW_END,
      S_REFILL,
      S_DONE
   } state_t;

   localparam logic [6:0] LAST_COL = 7'(ROW_LEN - 1);
   localparam logic [6:0] LAST_WIN = 7'(ROW_LEN - 3);
   localparam logic [9:0] ROWS_MAX = 10'(IMG_ROWS);

   state_t     state;
   state_t     state_next;
   logic [1:0] wr_sel;
   logic [9:0] rows_loaded;
   logic       wr_phase;
   logic       transfer;
   logic       row_last;

   function automatic logic [1:0] mod3_inc(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   assign wr_phase = (state == S_FILL) || (state == S_REFILL);
   assign in_ready = wr_phase;
   assign transfer = in_valid & wr_phase;
   assign row_last = (wr_addr == LAST_COL);
   assign rd_en    = (state == S_COMPUTE) && !conv_stall;
   assign wr_en    = transfer ? (3'b001 << wr_sel) : 3'b000;
   assign busy     = (state != S_IDLE);

   always_comb begin
      state_next = state;
      row_done   = 1'b0;
      frame_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_FILL;
         end
         S_FILL: begin
            if (transfer && row_last && rows_loaded == 10'd2) state_next = S_COMPUTE;
         end
         S_REFILL: begin
            if (transfer && row_last) state_next = S_COMPUTE;
         end
         S_COMPUTE: begin
            if (rd_en && rd_addr == LAST_WIN) state_next = S_ROW_END;
         end
         S_ROW_END: begin
            row_done   = 1'b1;
            state_next = (rows_loaded == ROWS_MAX) ? S_DONE : S_REFILL;
         end
         S_DONE: begin
            frame_done = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // The initial fill rotates wr_sel; refills always target the oldest row k and then rotate k.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wr_addr     <= '0;
         rd_addr     <= '0;
         k           <= '0;
         wr_sel      <= '0;
         rows_loaded <= '0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: begin
               if (start) begin
                  wr_addr     <= '0;
                  rd_addr     <= '0;
                  k           <= '0;
                  wr_sel      <= '0;
                  rows_loaded <= '0;
               end
            end
            S_FILL, S_REFILL: begin
               if (transfer) begin
                  if (row_last) begin
                     wr_addr     <= '0;
                     rows_loaded <= rows_loaded + 10'd1;
                     if (state == S_FILL) wr_sel <= mod3_inc(wr_sel);
                     else                 k      <= mod3_inc(k);
                  end else begin
                     wr_addr <= wr_addr + 7'd1;
                  end
               end
            end
            S_COMPUTE: begin
               if (rd_en) rd_addr <= (rd_addr == LAST_WIN) ? 7'd0 : rd_addr + 7'd1;
            end
            S_ROW_END: begin
               wr_sel <= k;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// tb/tb_line_buffer_scheduler.sv - randomized bench checking the scheduler against a row/window dependency model
module tb_line_buffer_scheduler;

   localparam int ROW_LEN  = 8;
   localparam int IMG_ROWS = 5;
   localparam int WIN      = ROW_LEN - 2;
   localparam int FRAME_CYC = 3 * ROW_LEN + (IMG_ROWS - 2) * (WIN + 1) + (IMG_ROWS - 3) * ROW_LEN + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] wr_en;
   logic [6:0] wr_addr;
   logic       conv_stall;
   logic       rd_en;
   logic [6:0] rd_addr;
   logic [1:0] k;
   logic       row_done;
   logic       frame_done;
   logic       busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   line_buffer_scheduler #(
      .ROW_LEN  (ROW_LEN),
      .IMG_ROWS (IMG_ROWS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .conv_stall (conv_stall),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .k          (k),
      .row_done   (row_done),
      .frame_done (frame_done),
      .busy       (busy)
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_in_ready"},   in_ready,   0);
      check_val({tag, "_wr_en"},      wr_en,      0);
      check_val({tag, "_wr_addr"},    wr_addr,    0);
      check_val({tag, "_rd_en"},      rd_en,      0);
      check_val({tag, "_rd_addr"},    rd_addr,    0);
      check_val({tag, "_k"},          k,          0);
      check_val({tag, "_row_done"},   row_done,   0);
      check_val({tag, "_frame_done"}, frame_done, 0);
      check_val({tag, "_busy"},       busy,       0);
   endtask

   // Model: row r goes to buffer r%3; window j reads column rcnt%WIN with top row j%3 and
   // needs rows j..j+2 written; row r>=3 may only be written once output row r-3 is finished.
   task automatic run_frame(input int vpct, input int spct, input bit rnd_start,
                            input int abort_at, input int exp_cycles);
      int wcnt = 0;
      int rcnt = 0;
      int rdone = 0;
      int fdone = 0;
      int cyc = 0;
      int r;
      int j;
      bit accepted = 1'b0;
      start      = 1'b1;
      in_valid   = 1'b0;
      conv_stall = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (busy) begin
            accepted = 1'b1;
            break;
         end
      end
      check_val("start_accept", accepted, 1);
      if (!accepted) begin
         start = 1'b0;
         return;
      end
      while (fdone == 0 && cyc < 3000) begin
         in_valid   = ($urandom_range(99) < vpct);
         conv_stall = ($urandom_range(99) < spct);
         start      = rnd_start ? 1'($urandom_range(1)) : 1'b0;
         @(negedge clk);
         cyc++;
         check_val("busy", busy, 1);
         check_val("wr_rd_excl", (wr_en != 0) && rd_en, 0);
         check_val("wr_gate", wr_en != 0, in_valid && in_ready);
         check_val("stall_gate", rd_en && conv_stall, 0);
         r = wcnt / ROW_LEN;
         if (wcnt % ROW_LEN != 0) check_val("ready_hold", in_ready, 1);
         if (in_ready) check_val("ready_allowed", (r < IMG_ROWS) && (r < 3 || rcnt >= (r - 2) * WIN), 1);
         if (rcnt % WIN != 0) check_val("rd_cont", rd_en, !conv_stall);
         if (in_ready && in_valid) begin
            check_val("wr_en", wr_en, 1 << (r % 3));
            check_val("wr_addr", wr_addr, wcnt % ROW_LEN);
            wcnt++;
         end
         if (rd_en) begin
            j = rcnt / WIN;
            check_val("rd_addr", rd_addr, rcnt % WIN);
            check_val("k", k, j % 3);
            check_val("rd_ready", (j < IMG_ROWS - 2) && (wcnt >= (j + 3) * ROW_LEN), 1);
            rcnt++;
         end
         if (row_done) begin
            rdone++;
            check_val("row_done_at", rcnt, rdone * WIN);
         end
         if (frame_done) begin
            fdone++;
            check_val("frame_writes", wcnt, IMG_ROWS * ROW_LEN);
            check_val("frame_windows", rcnt, (IMG_ROWS - 2) * WIN);
            check_val("frame_rows_done", rdone, IMG_ROWS - 2);
            if (exp_cycles > 0) check_val("frame_cycles", cyc, exp_cycles);
         end
         if (abort_at >= 0 && wcnt == abort_at + 1) begin
            rst   = 1'b1;
            start = 1'b1;
            @(posedge clk);
            #1;
            check_idle("abort");
            rst   = 1'b0;
            start = 1'b0;
            @(posedge clk);
            #1;
            check_val("start_in_rst_ignored", busy, 0);
            in_valid   = 1'b0;
            conv_stall = 1'b0;
            return;
         end
         if (fdone == 0) begin
            @(posedge clk);
            #1;
         end
      end
      if (fdone == 0) check_val("frame_timeout", 0, 1);
      start      = 1'b0;
      in_valid   = 1'b0;
      conv_stall = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      in_valid   = 1'b1;
      conv_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      @(negedge clk);
      rst = 1'b0;

      run_frame(100, 0, 1'b0, -1, FRAME_CYC);
      run_frame(100, 0, 1'b0, -1, FRAME_CYC);
      repeat (3) @(negedge clk);
      check_val("idle_busy", busy, 0);

      run_frame(100, 0, 1'b0, 3 * ROW_LEN + 4, 0);
      run_frame(100, 0, 1'b0, -1, FRAME_CYC);
      run_frame(50, 0, 1'b1, -1, 0);

      for (int n = 0; n < 8; n++) begin
         run_frame(int'($urandom_range(100, 30)), int'($urandom_range(50)), 1'b1, -1, 0);
         if (n % 2 == 1) begin
            repeat (2) @(negedge clk);
            check_val("gap_busy", busy, 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
